fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined core. Owns the program counter, drives the word address of the registered instruction ROM, and aligns the ROM's one-cycle-late data with the PC it belongs to, presenting a (pc, instruction, valid) triple to the IF/ID boundary. Supports decode-side stalls with zero-bubble restart and EX-side redirects (taken branches, jumps) with a one-cycle refill.

## Interface
- data_width, 32, instruction width; must match the ROM.
- addr_width, 10, ROM word-address width; PC bits [addr_width+1:2] form the ROM address.
- RESET_PC, 32'h0000_0000, byte address of the first fetched instruction.
- CLK  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hold the current output triple (decode not accepting).
- redirect_i  in  1  change the fetch stream to redirect_pc_i; has priority over stall_i.
- redirect_pc_i  in  32  redirect target byte address; bits [1:0] ignored (treated as 0).
- iaddr  out  addr_width  word address to the ROM (combinational).
- idata  in  data_width  ROM data, valid one cycle after iaddr.
- if_pc  out  32  byte address of the instruction on if_instr.
- if_instr  out  data_width  idata when if_valid=1, else 32'h0000_0013 (NOP).
- if_valid  out  1  if_instr/if_pc are a real fetched instruction.
- fetch_count  out  32  present only with FETCH_PERF_CNT_EN.
- redirect_count  out  32  present only with FETCH_PERF_CNT_EN.

## Operation
- State: pc_q (address presented to the ROM, the next instruction), out_pc_q (address whose data is on idata), valid_q.
- Reset values: pc_q=RESET_PC, out_pc_q=0, valid_q=0; hence if_pc=0, if_instr=NOP, if_valid=0, counters=0.
- iaddr selection, priority order:
  - redirect_i: redirect_pc_i[addr_width+1:2].
  - stall_i: out_pc_q[addr_width+1:2]. Re-reads the displayed instruction so idata stays stable.
  - else: pc_q[addr_width+1:2].
- Register update per cycle, same priority:
  - redirect: out_pc_q<=target, pc_q<=target+4, valid_q<=1.
  - stall: all hold.
  - advance: out_pc_q<=pc_q, pc_q<=pc_q+4, valid_q<=1.
- The instruction displayed in a redirect cycle is wrong-path. fetch_unit does not mask it; downstream flush logic squashes it.
- PC arithmetic is 32-bit modulo 2^32. The ROM address wraps modulo 2^addr_width words; no out-of-range detection.
- if_pc/if_instr/if_valid depend only on registers and idata, never on stall_i or redirect_i.

## Timing
- Fetch latency: 1 cycle from iaddr to matching if_instr.
- First instruction after RST deasserts: if_valid=1, if_pc=RESET_PC on the first edge after release.
- Steady state: one instruction per cycle, if_pc increments by 4.
- Stall: outputs frozen for every stalled cycle. Release resumes with pc_q on the next edge; no bubble, no duplicate.
- Redirect: target instruction appears on the edge after redirect_i. Exactly one wrong-path instruction is displayed (the redirect cycle's).
- Redirect and stall together: the redirect wins; the stall is ignored for that cycle.
- RST asserted mid-operation: all state clears immediately (asynchronously); if_valid drops without waiting for a clock.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - fetch_count increments on each edge where if_valid=1, stall_i=0 and redirect_i=0 (an instruction handed downstream).
  - redirect_count increments on each edge with redirect_i=1.
  - Both are 32-bit, wrap, and clear on RST.
- FETCH_PERF_CNT_EN undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- Reset/sequential: RST pulse, RESET_PC=0, ROM[i]=i+1 → if_valid=0 at reset; then if_pc=0,4,8 with if_instr=1,2,3 on consecutive cycles.
- Stall: stall_i high 3 cycles while if_pc=8 → if_pc=8, if_instr=3 held for 3 cycles; next cycles show 12/4 and 16/5, with no gap or repeat.
- Redirect: redirect_i with redirect_pc_i=0x40 while if_pc=8 → next cycle if_pc=0x40, if_instr=ROM[16]; then 0x44. A target of 0x43 behaves as 0x40.
- Redirect+stall: both high in the same cycle → redirect is taken, next if_pc=target; fetch_count does not increment that edge.
- Async reset mid-stream: assert RST between edges → if_valid=0 and if_pc=0 before the next edge; fetch restarts at RESET_PC.
- Wrap and counters (FETCH_PERF_CNT_EN): with addr_width=4, fetch past 0x3C → iaddr wraps to 0, if_pc=0x40 shows ROM[0]. Ten advances plus 2 redirects → fetch_count=10, redirect_count=2.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and aligns one-cycle-late ROM data with its PC.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int unsigned data_width = 32,
    parameter int unsigned addr_width = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic [addr_width-1:0] iaddr,
    input  logic [data_width-1:0] idata,
    output logic [31:0]           if_pc,
    output logic [data_width-1:0] if_instr,
    output logic                  if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           redirect_count
`endif
);

    localparam logic [data_width-1:0] NOP = data_width'(32'h0000_0013);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] out_pc_q;
    logic [31:0] out_pc_d;
    logic        valid_q;
    logic        valid_d;
    logic [31:0] target;
    logic        handoff;
    logic        unused_tgt_lsb;

    assign target         = {redirect_pc_i[31:2], 2'b00};
    assign unused_tgt_lsb = ^redirect_pc_i[1:0];
    assign handoff        = valid_q & ~stall_i & ~redirect_i;

    // Stall re-reads the displayed word so idata stays stable while held.
    always_comb begin
        pc_d     = pc_q;
        out_pc_d = out_pc_q;
        valid_d  = valid_q;
        iaddr    = pc_q[addr_width+1:2];
        if (redirect_i) begin
            iaddr    = redirect_pc_i[addr_width+1:2];
            out_pc_d = target;
            pc_d     = target + 32'd4;
            valid_d  = 1'b1;
        end else if (stall_i) begin
            iaddr    = out_pc_q[addr_width+1:2];
        end else begin
            out_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q     <= RESET_PC;
            out_pc_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            out_pc_q <= out_pc_d;
            valid_q  <= valid_d;
        end
    end

    assign if_pc    = out_pc_q;
    assign if_valid = valid_q;
    assign if_instr = valid_q ? idata : NOP;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [31:0] redir_cnt_q;
    logic [31:0] redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (handoff) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (redirect_i) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt_q <= 32'h0;
            redir_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign fetch_count    = fetch_cnt_q;
    assign redirect_count = redir_cnt_q;
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a stream-level model of the fetch sequence.
module tb_fetch_unit;

    localparam int          AW  = 5;
    localparam int          DW  = 32;
    localparam int          RW  = 1 << AW;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          CLK = 1'b0;
    logic          RST;
    logic          stall_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic [31:0]   if_pc;
    logic [DW-1:0] if_instr;
    logic          if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   fetch_count;
    logic [31:0]   redirect_count;
`endif

    fetch_unit #(
        .data_width(DW),
        .addr_width(AW),
        .RESET_PC  (RPC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .iaddr         (iaddr),
        .idata         (idata),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_valid      (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .redirect_count(redirect_count)
`endif
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] rom [0:RW-1];
    always @(posedge CLK) idata <= rom[iaddr];

    int total = 0;
    int bad   = 0;

    // Model: displayed stream position, next sequential address, counters.
    logic [31:0]   m_pc;
    logic [31:0]   m_next;
    bit            m_valid;
    logic [31:0]   m_fc;
    logic [31:0]   m_rc;
    logic [AW-1:0] exp_iaddr;
    logic [AW-1:0] got_iaddr;

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return AW'((a / 4) % RW);
    endfunction

    function automatic logic [31:0] m_instr();
        return m_valid ? rom[word_of(m_pc)] : NOP;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_next  = RPC;
        m_valid = 0;
        m_fc    = 0;
        m_rc    = 0;
    endtask

    // One clock: drive inputs, sample iaddr, advance model, settle past edge.
    task automatic cyc(input bit r, input bit s, input logic [31:0] t);
        redirect_i    = r;
        stall_i       = s;
        redirect_pc_i = t;
        #1;
        if (r)      exp_iaddr = word_of(t);
        else if (s) exp_iaddr = word_of(m_pc);
        else        exp_iaddr = word_of(m_next);
        got_iaddr = iaddr;
        @(posedge CLK);
        if (m_valid && !s && !r) m_fc = m_fc + 1;
        if (r) m_rc = m_rc + 1;
        if (r) begin
            m_pc    = t - (t % 4);
            m_next  = m_pc + 4;
            m_valid = 1;
        end else if (!s) begin
            m_pc    = m_next;
            m_next  = m_next + 4;
            m_valid = 1;
        end
        #1;
        redirect_i = 0;
        stall_i    = 0;
    endtask

    task automatic test_reset();
        RST = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        @(posedge CLK); @(posedge CLK); #1;
        model_reset();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", if_valid); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", if_pc); end
        total++; if (if_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h want=%h", if_instr, NOP); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (fetch_count !== 0 || redirect_count !== 0) begin
            bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", fetch_count, redirect_count);
        end
`endif
        RST = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0);
            total++; if (got_iaddr !== AW'(k)) begin bad++; $display("FAIL seq_iaddr got=%0d want=%0d", got_iaddr, k); end
            total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b want=1", if_valid); end
            total++; if (if_pc !== 32'(4 * k)) begin bad++; $display("FAIL seq_pc got=%h want=%h", if_pc, 4 * k); end
            total++; if (if_instr !== 32'(k + 1)) begin bad++; $display("FAIL seq_instr got=%h want=%h", if_instr, k + 1); end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0);
            total++; if (got_iaddr !== AW'(2)) begin bad++; $display("FAIL stall_iaddr got=%0d want=2", got_iaddr); end
            total++; if (if_pc !== 32'h8 || if_instr !== 32'h3) begin
                bad++; $display("FAIL stall_hold got=%h/%h want=8/3", if_pc, if_instr);
            end
        end
        cyc(0, 0, 0);
        total++; if (if_pc !== 32'hC || if_instr !== 32'h4) begin
            bad++; $display("FAIL stall_rel1 got=%h/%h want=c/4", if_pc, if_instr);
        end
        cyc(0, 0, 0);
        total++; if (if_pc !== 32'h10 || if_instr !== 32'h5) begin
            bad++; $display("FAIL stall_rel2 got=%h/%h want=10/5", if_pc, if_instr);
        end
    endtask

    task automatic test_redirect();
        cyc(1, 0, 32'h40);
        total++; if (got_iaddr !== AW'(16)) begin bad++; $display("FAIL redir_iaddr got=%0d want=16", got_iaddr); end
        total++; if (if_pc !== 32'h40 || if_instr !== 32'd17 || if_valid !== 1'b1) begin
            bad++; $display("FAIL redir_tgt got=%h/%h want=40/11", if_pc, if_instr);
        end
        cyc(0, 0, 0);
        total++; if (if_pc !== 32'h44 || if_instr !== 32'd18) begin
            bad++; $display("FAIL redir_next got=%h/%h want=44/12", if_pc, if_instr);
        end
        cyc(1, 0, 32'h43);
        total++; if (if_pc !== 32'h40 || if_instr !== 32'd17) begin
            bad++; $display("FAIL redir_lsb got=%h/%h want=40/11", if_pc, if_instr);
        end
        cyc(0, 0, 0);
        total++; if (if_pc !== 32'h44) begin bad++; $display("FAIL redir_lsb_next got=%h want=44", if_pc); end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] fc0;
        logic [31:0] rc0;
        fc0 = m_fc;
        rc0 = m_rc;
        cyc(1, 1, 32'h20);
        total++; if (if_pc !== 32'h20 || if_instr !== 32'd9) begin
            bad++; $display("FAIL rs_tgt got=%h/%h want=20/9", if_pc, if_instr);
        end
        total++; if (fc0 !== m_fc || rc0 + 1 !== m_rc) begin
            bad++; $display("FAIL rs_model got=%0d/%0d want=%0d/%0d", m_fc, m_rc, fc0, rc0 + 1);
        end
`ifdef FETCH_PERF_CNT_EN
        total++; if (fetch_count !== fc0 || redirect_count !== rc0 + 1) begin
            bad++; $display("FAIL rs_cnt got=%0d/%0d want=%0d/%0d", fetch_count, redirect_count, fc0, rc0 + 1);
        end
`endif
        cyc(0, 0, 0);
        total++; if (if_pc !== 32'h24) begin bad++; $display("FAIL rs_next got=%h want=24", if_pc); end
    endtask

    task automatic test_wrap();
        cyc(1, 0, 32'h78);
        cyc(0, 0, 0);
        total++; if (if_pc !== 32'h7C || if_instr !== 32'd32) begin
            bad++; $display("FAIL wrap_last got=%h/%h want=7c/20", if_pc, if_instr);
        end
        cyc(0, 0, 0);
        total++; if (got_iaddr !== AW'(0)) begin bad++; $display("FAIL wrap_iaddr got=%0d want=0", got_iaddr); end
        total++; if (if_pc !== 32'h80 || if_instr !== 32'd1) begin
            bad++; $display("FAIL wrap_rom got=%h/%h want=80/1", if_pc, if_instr);
        end
        cyc(1, 0, 32'hFFFF_FFF8);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        total++; if (if_pc !== 32'h0 || if_instr !== 32'd1) begin
            bad++; $display("FAIL wrap_pc32 got=%h/%h want=0/1", if_pc, if_instr);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) cyc(0, 0, 0);
        RST = 1;
        #1;
        total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP) begin
            bad++; $display("FAIL arst got=%b/%h/%h want=0/0/13", if_valid, if_pc, if_instr);
        end
        model_reset();
        #1;
        RST = 0;
        cyc(0, 0, 0);
        total++; if (if_valid !== 1'b1 || if_pc !== RPC || if_instr !== 32'd1) begin
            bad++; $display("FAIL arst_restart got=%b/%h/%h want=1/%h/1", if_valid, if_pc, if_instr, RPC);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_counters();
        RST = 1;
        #1;
        model_reset();
        #1;
        RST = 0;
        cyc(0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0);
        cyc(1, 0, 32'h10);
        cyc(0, 1, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0);
        cyc(1, 0, 32'h30);
        total++; if (fetch_count !== 32'd10 || redirect_count !== 32'd2) begin
            bad++; $display("FAIL cnt got=%0d/%0d want=10/2", fetch_count, redirect_count);
        end
    endtask
`endif

    task automatic test_random();
        bit          r;
        bit          s;
        logic [31:0] t;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 99) < 15);
            s = ($urandom_range(0, 99) < 25);
            t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cyc(r, s, t);
            total++; if (got_iaddr !== exp_iaddr) begin
                bad++; $display("FAIL rnd_iaddr n=%0d got=%0d want=%0d", n, got_iaddr, exp_iaddr);
            end
            total++; if (if_valid !== m_valid || if_pc !== m_pc) begin
                bad++; $display("FAIL rnd_pc n=%0d got=%b/%h want=%b/%h", n, if_valid, if_pc, m_valid, m_pc);
            end
            total++; if (if_instr !== m_instr()) begin
                bad++; $display("FAIL rnd_instr n=%0d got=%h want=%h", n, if_instr, m_instr());
            end
`ifdef FETCH_PERF_CNT_EN
            total++; if (fetch_count !== m_fc || redirect_count !== m_rc) begin
                bad++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, fetch_count, redirect_count, m_fc, m_rc);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < RW; i++) rom[i] = 32'(i + 1);
        RST = 1;
        stall_i = 0;
        redirect_i = 0;
        redirect_pc_i = 0;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_counters();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
